// File: rtl/baccarat_pkg.sv
// Shared Baccarat datapath types, card code constants and helpers.
// Imported by the hand scorer and its card value decoder.
package baccarat_pkg;

    localparam int CARD_W  = 4;
    localparam int SCORE_W = 4;

    typedef logic [CARD_W-1:0]  card_t;
    typedef logic [SCORE_W-1:0] score_t;

    localparam card_t CARD_NONE  = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_TEN   = 4'd10;
    localparam card_t CARD_JACK  = 4'd11;
    localparam card_t CARD_QUEEN = 4'd12;
    localparam card_t CARD_KING  = 4'd13;

    // Operand never exceeds 27, so at most two subtractions of 10.
    function automatic score_t mod10(input logic [4:0] x);
        logic [4:0] r;
        r = x;
        if (r >= 5'd20) begin
            r = r - 5'd20;
        end else if (r >= 5'd10) begin
            r = r - 5'd10;
        end
        return r[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/card_value.sv
// Combinational card code to Baccarat point value decoder.
// Ports: code (card code in), value (points 0..9 out), illegal (code 14/15).
module card_value
    import baccarat_pkg::*;
(
    input  card_t  code,
    output score_t value,
    output logic   illegal
);

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        if (code > CARD_KING) begin
            illegal = 1'b1;
        end else if (code < CARD_TEN) begin
            // Covers CARD_NONE, CARD_ACE and pips; tens and faces stay 0.
            value = code;
        end
    end

endmodule

// File: rtl/score_hand.sv
// Baccarat hand scorer: registered total, two-card total, natural and
// illegal-card flags with one clock of latency.
// Ports: clk, reset (sync, active-high), in_valid, card1..card3 in;
//        total, two_card_total, natural, bad_card, out_valid out.
module score_hand
    import baccarat_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [CARD_W-1:0]   card1,
    input  logic [CARD_W-1:0]   card2,
    input  logic [CARD_W-1:0]   card3,
    output logic [SCORE_W-1:0]  total,
    output logic [SCORE_W-1:0]  two_card_total,
    output logic                natural,
    output logic                bad_card,
    output logic                out_valid
);

    score_t v1, v2, v3;
    logic   ill1, ill2, ill3;

    card_value u_cv1 (.code(card1), .value(v1), .illegal(ill1));
    card_value u_cv2 (.code(card2), .value(v2), .illegal(ill2));
    card_value u_cv3 (.code(card3), .value(v3), .illegal(ill3));

    logic [4:0] sum2;
    logic [4:0] sum3;
    score_t     two_mod;
    score_t     tot_mod;

    score_t total_q, total_d;
    score_t two_q, two_d;
    logic   natural_q, natural_d;
    logic   bad_q, bad_d;
    logic   valid_q, valid_d;

    always_comb begin
        sum2    = {1'b0, v1} + {1'b0, v2};
        sum3    = sum2 + {1'b0, v3};
        two_mod = mod10(sum2);
        tot_mod = mod10(sum3);

        // Hold results when no sample is presented.
        total_d   = total_q;
        two_d     = two_q;
        natural_d = natural_q;
        bad_d     = bad_q;
        valid_d   = in_valid;

        if (in_valid) begin
            total_d   = tot_mod;
            two_d     = two_mod;
            natural_d = (two_mod >= 4'd8) && (v3 == '0);
            bad_d     = ill1 | ill2 | ill3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q   <= '0;
            two_q     <= '0;
            natural_q <= 1'b0;
            bad_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            total_q   <= total_d;
            two_q     <= two_d;
            natural_q <= natural_d;
            bad_q     <= bad_d;
            valid_q   <= valid_d;
        end
    end

    assign total          = total_q;
    assign two_card_total = two_q;
    assign natural        = natural_q;
    assign bad_card       = bad_q;
    assign out_valid      = valid_q;

endmodule

// File: tb/tb_score_hand.sv
// Directed bench for score_hand with hand-computed expectations.
// Drives on the falling edge and samples 1 time unit after the rising edge.
module tb_score_hand;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] card1, card2, card3;
    logic [3:0] total, two_card_total;
    logic       natural, bad_card, out_valid;

    int n_chk;
    int n_fail;

    score_hand dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .card1          (card1),
        .card2          (card2),
        .card3          (card3),
        .total          (total),
        .two_card_total (two_card_total),
        .natural        (natural),
        .bad_card       (bad_card),
        .out_valid      (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample, then check every output one clock later.
    task automatic hand(input logic [3:0] c1, input logic [3:0] c2,
                        input logic [3:0] c3, input logic [3:0] e_tot,
                        input logic [3:0] e_two, input logic e_nat,
                        input logic e_bad);
        string tag;
        @(negedge clk);
        in_valid = 1'b1;
        card1 = c1;
        card2 = c2;
        card3 = c3;
        @(posedge clk);
        #1;
        tag = $sformatf("(%0d,%0d,%0d)", c1, c2, c3);
        check({tag, " total"}, {4'd0, total}, {4'd0, e_tot});
        check({tag, " two"}, {4'd0, two_card_total}, {4'd0, e_two});
        check({tag, " natural"}, {7'd0, natural}, {7'd0, e_nat});
        check({tag, " bad"}, {7'd0, bad_card}, {7'd0, e_bad});
        check({tag, " valid"}, {7'd0, out_valid}, 8'd1);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        in_valid = 1'b1;
        card1    = 4'd9;
        card2    = 4'd9;
        card3    = 4'd9;
        @(posedge clk);
        #1;
        check("rst total", {4'd0, total}, 8'd0);
        check("rst two", {4'd0, two_card_total}, 8'd0);
        check("rst natural", {7'd0, natural}, 8'd0);
        check("rst bad", {7'd0, bad_card}, 8'd0);
        check("rst valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // Sweep through face cards and pips, back to back.
        hand(4'd13, 4'd0,  4'd0,  4'd0, 4'd3 - 4'd3, 1'b0, 1'b0);
        hand(4'd12, 4'd1,  4'd1,  4'd2, 4'd1, 1'b0, 1'b0);
        hand(4'd9,  4'd4,  4'd4,  4'd7, 4'd3, 1'b0, 1'b0);
        hand(4'd5,  4'd8,  4'd8,  4'd1, 4'd3, 1'b0, 1'b0);
        hand(4'd4,  4'd9,  4'd9,  4'd2, 4'd3, 1'b0, 1'b0);
        hand(4'd2,  4'd11, 4'd11, 4'd2, 4'd2, 1'b0, 1'b0);

        // Wrap-around.
        hand(4'd9,  4'd9,  4'd9,  4'd7, 4'd8, 1'b0, 1'b0);
        hand(4'd1,  4'd9,  4'd0,  4'd0, 4'd0, 1'b0, 1'b0);
        hand(4'd10, 4'd10, 4'd10, 4'd0, 4'd0, 1'b0, 1'b0);
        hand(4'd0,  4'd0,  4'd7,  4'd7, 4'd0, 1'b0, 1'b0);

        // Naturals.
        hand(4'd4,  4'd4,  4'd0,  4'd8, 4'd8, 1'b1, 1'b0);
        hand(4'd4,  4'd4,  4'd1,  4'd9, 4'd8, 1'b0, 1'b0);
        hand(4'd13, 4'd9,  4'd0,  4'd9, 4'd9, 1'b1, 1'b0);
        hand(4'd6,  4'd3,  4'd12, 4'd9, 4'd9, 1'b1, 1'b0);

        // Illegal codes in each position.
        hand(4'd14, 4'd3,  4'd0,  4'd3, 4'd3, 1'b0, 1'b1);
        hand(4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 1'b0, 1'b1);
        hand(4'd2,  4'd3,  4'd15, 4'd5, 4'd5, 1'b0, 1'b1);
        hand(4'd0,  4'd14, 4'd2,  4'd2, 4'd0, 1'b0, 1'b1);
        hand(4'd3,  4'd4,  4'd0,  4'd7, 4'd7, 1'b0, 1'b0);

        // Idle cycle: valid drops, results hold.
        @(negedge clk);
        in_valid = 1'b0;
        card1 = 4'd9;
        card2 = 4'd9;
        card3 = 4'd15;
        @(posedge clk);
        #1;
        check("idle valid", {7'd0, out_valid}, 8'd0);
        check("idle total", {4'd0, total}, 8'd7);
        check("idle two", {4'd0, two_card_total}, 8'd7);
        check("idle bad", {7'd0, bad_card}, 8'd0);

        // Reset mid-stream beats a valid sample.
        hand(4'd4, 4'd5, 4'd0, 4'd9, 4'd9, 1'b1, 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        card1 = 4'd14;
        card2 = 4'd4;
        card3 = 4'd3;
        @(posedge clk);
        #1;
        check("mid rst total", {4'd0, total}, 8'd0);
        check("mid rst natural", {7'd0, natural}, 8'd0);
        check("mid rst bad", {7'd0, bad_card}, 8'd0);
        check("mid rst valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        hand(4'd8, 4'd0, 4'd0, 4'd8, 4'd8, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/score_hand.md
Name: score_hand

Overview:
- Baccarat hand scorer in the Baccarat engine datapath, one instance per hand (player, banker).
- Takes up to three 4-bit card codes and produces the hand score: the sum of the card point values, modulo 10.
- Results are registered, with one cycle of latency, on a single clock.
- Also flags a "natural" two-card score (8 or 9) and illegal card codes, for use by the game-control FSM.

Parameters:
- CARD_W, 4, card code width (fixed; not for override).
- SCORE_W, 4, score width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  card1..card3 are valid this cycle and must be scored.
- card1  in  4  first card code.
- card2  in  4  second card code.
- card3  in  4  third card code (0 = not dealt).
- total  out  4  registered hand score, 0..9.
- two_card_total  out  4  registered (card1 + card2) mod 10, 0..9.
- natural  out  1  registered; two_card_total is 8 or 9 and card3 value is 0.
- bad_card  out  1  registered; any input code is 14 or 15.
- out_valid  out  1  registered; outputs correspond to an in_valid sample.

Behaviour:
- Card code to point value mapping:
  - 0 (no card) -> 0.
  - 1 (Ace) -> 1.
  - 2..9 -> face value.
  - 10, 11 (J), 12 (Q), 13 (K) -> 0.
  - 14, 15 (illegal) -> 0, and bad_card is set.
- total = (v1 + v2 + v3) mod 10.
  - Intermediate sum is at least 5 bits (maximum 27).
  - mod 10 is done by compare/subtract (subtract 10 once or twice); no divider.
- two_card_total = (v1 + v2) mod 10.
- natural = (two_card_total >= 8) and (v3 == 0).
- Latency: exactly 1 clock.
  - On a rising edge with in_valid = 1, all outputs load the results computed from that cycle's inputs, and out_valid goes to 1.
  - On a rising edge with in_valid = 0: out_valid goes to 0; total, two_card_total, natural and bad_card hold their previous values.
- Reset: on a rising edge with reset = 1, all outputs are cleared: total = 0, two_card_total = 0, natural = 0, bad_card = 0, out_valid = 0.
  - reset has priority over in_valid.
  - Reset mid-stream discards the sample presented in that cycle.
- Back-to-back in_valid is supported every cycle (throughput 1 per clock); there is no backpressure.
- Inputs are purely combinational up to the register. No internal state other than the output registers.
- Output values are order-independent for card1..card3, except for natural and two_card_total, which use only card1 and card2.

Decomposition:
- Shared package baccarat_pkg:
  - card code constants: CARD_NONE = 0, CARD_ACE = 1, CARD_TEN = 10, CARD_JACK = 11, CARD_QUEEN = 12, CARD_KING = 13.
  - card_t (logic [3:0]) and score_t (logic [3:0]) typedefs.
  - a mod10 function for a 5-bit operand.
- One sub-module, card_value: 4-bit code in; 4-bit point value and illegal flag out; combinational. Instantiated three times.

Test Plan:
- Reset: assert reset with in_valid = 1 and cards (9,9,9) -> after the edge total = 0, out_valid = 0, natural = 0, bad_card = 0.
- Face cards and sweep: card1 13, card2 0, card3 0 -> total 0.
  - Then walk card1 down and card2, card3 up together: (12,1,1) -> 2; (9,4,4) -> 7; (5,8,8) -> 1; (4,9,9) -> 2; (2,11,11) -> 2.
  - Each result appears one clock after the sample, with out_valid = 1.
- Wrap-around: (9,9,9) -> total 7; (1,9,0) -> total 0; (10,10,10) -> total 0.
- Natural: (4,4,0) -> two_card_total 8, natural 1. (4,4,1) -> total 9, natural 0. (13,9,0) -> natural 1.
- Illegal codes: (14,3,0) -> bad_card 1, total 3. (15,15,15) -> bad_card 1, total 0.
- Hold and throughput: samples on consecutive cycles produce consecutive results. Dropping in_valid makes out_valid 0 next cycle while total holds its last value.
